player_move_ctrl: RTL
=====================

PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 SHALL have parameter STEP_PIXELS, default 32, which is the display pixels moved per accepted request (one tile).
REQ-002 SHALL have parameter DELAY_LOG, default 5, so that one pixel step occurs every 2^DELAY_LOG clk_13 cycles.
REQ-003 SHALL have parameters ROW_MIN 0, ROW_MAX 448, COL_MIN 0, COL_MAX 608, which are the inclusive legal sprite top-left bounds.
REQ-004 SHALL have parameters RST_ROW 300 and RST_COL 300, which are the position after reset.
REQ-005 SHALL have port clk_13  in  1: system clock, rising edge.
REQ-006 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-007 SHALL have ports btn_up, btn_down, btn_left, btn_right  in  1 each: debounced level requests.
REQ-008 SHALL have ports player_r, player_c  out  10 each: sprite top-left row and column.
REQ-009 SHALL have port move_dir  out  3: STOP=0, DOWN=1, UP=2, LEFT=3, RIGHT=4.
REQ-010 SHALL have port frame_sel  out  1: walk-frame select for the sprite ROM mux.
REQ-011 SHALL have port busy  out  1: high while a tile move is in progress.

Function
REQ-012 SHALL implement FSM states IDLE and MOVE; busy=1 only in MOVE; move_dir=STOP in IDLE.
REQ-013 SHALL arbitrate simultaneous buttons with fixed priority up > down > left > right.
REQ-014 In IDLE with any button high, SHALL accept the winner if target = position ±STEP_PIXELS lies within bounds: next cycle MOVE, move_cnt = STEP_PIXELS*2^DELAY_LOG-1.
REQ-015 SHALL drop an out-of-bounds request, stay in IDLE, and leave position unchanged.
REQ-016 move_cnt width SHALL be log2(STEP_PIXELS)+DELAY_LOG; in MOVE it SHALL decrement by 1 per cycle.
REQ-017 In MOVE, SHALL change position by exactly 1 in move_dir on every edge where move_cnt[DELAY_LOG-1:0]==0 (STEP_PIXELS steps in total; up = row-1, left = col-1).
REQ-018 SHALL keep a one-entry pending register: during MOVE, if it is empty, it captures the highest-priority held button; further presses are ignored.
REQ-019 At move_cnt==0 in MOVE, SHALL go to MOVE with the pending direction if pending is valid and in bounds (reload counter, clear pending, no IDLE cycle); otherwise go to IDLE and clear pending.
REQ-020 SHALL start each tile move exactly 1024 cycles (defaults) apart when chained.
REQ-021 All position arithmetic SHALL be 10-bit unsigned; the bounds check prevents wrap-around.

Reset
REQ-022 On rst SHALL immediately set state=IDLE, player_r=RST_ROW, player_c=RST_COL, move_cnt=0, pending empty, move_dir=0, frame_sel=0, busy=0, including when a move is in progress.

Configuration
REQ-023 With WALK_ANIM_EN defined, frame_sel SHALL equal the move_cnt MSB inverted in MOVE (frame 0 for the first half, frame 1 for the second half) and SHALL be 0 in IDLE.
REQ-024 Without WALK_ANIM_EN, frame_sel SHALL be constant 0.

Structure
REQ-025 The move_dir encodings and the FSM state encodings SHALL live in a shared package, game_pkg.
REQ-026 Priority selection and the bounds check SHALL be one sub-module, move_arbiter (buttons and position in; dir and valid out).

Verification
REQ-027 Reset, then no buttons for 100 cycles -> player_r=300, player_c=300, move_dir=0, busy=0.
REQ-028 btn_up pulsed for 1 cycle -> busy for 1024 cycles, player_r decrements every 32 cycles to 268, then IDLE; with WALK_ANIM_EN, frame_sel rises after 512 cycles.
REQ-029 btn_up and btn_left both held -> move_dir=UP, player_c stays 300.
REQ-030 btn_right pulsed at cycle 200 of a down move -> the right move begins the cycle after the down move completes with busy continuously 1; final position (332,332).
REQ-031 RST_ROW=16, btn_up -> request rejected, busy stays 0, player_r=16.
REQ-032 rst asserted at cycle 500 of a left move -> position returns to (300,300) asynchronously, move_dir=0, and the next request starts a full 1024-cycle move.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg
// Shared encodings for the player movement logic:
//   dir_t   - move direction as seen on move_dir (STOP/DOWN/UP/LEFT/RIGHT)
//   state_t - movement FSM states (IDLE/MOVE)
//   pick_dir - fixed-priority button selection, up > down > left > right
package game_pkg;

    typedef enum logic [2:0] {
        DIR_STOP  = 3'd0,
        DIR_DOWN  = 3'd1,
        DIR_UP    = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

    function automatic dir_t pick_dir(input logic up, input logic down,
                                      input logic left, input logic right);
        dir_t d;
        if (up)         d = DIR_UP;
        else if (down)  d = DIR_DOWN;
        else if (left)  d = DIR_LEFT;
        else if (right) d = DIR_RIGHT;
        else            d = DIR_STOP;
        return d;
    endfunction

endpackage

// File: rtl/move_arbiter.sv
// move_arbiter
// Picks the winning direction among the requests (up > down > left > right)
// and reports whether one tile step in that direction keeps the sprite's
// top-left corner inside the inclusive bounds. A losing-priority button is
// never considered when the winner is out of bounds: the request is dropped.
// Ports:
//   btn_up/down/left/right : request levels
//   pos_r, pos_c           : current sprite position (10-bit)
//   dir                    : winning direction (DIR_STOP if none)
//   valid                  : a winner exists and its target is in bounds
module move_arbiter
    import game_pkg::*;
#(
    parameter int STEP_PIXELS = 32,
    parameter int ROW_MIN     = 0,
    parameter int ROW_MAX     = 448,
    parameter int COL_MIN     = 0,
    parameter int COL_MAX     = 608
) (
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [9:0] pos_r,
    input  logic [9:0] pos_c,
    output dir_t       dir,
    output logic       valid
);

    // Comparisons are done one bit wider so pos+STEP never wraps and
    // pos-STEP is never formed at all (compared as pos >= MIN+STEP).
    localparam logic [10:0] STEP_EXT = 11'(STEP_PIXELS);
    localparam logic [10:0] UP_MIN   = 11'(ROW_MIN + STEP_PIXELS);
    localparam logic [10:0] LEFT_MIN = 11'(COL_MIN + STEP_PIXELS);
    localparam logic [10:0] ROW_LIM  = 11'(ROW_MAX);
    localparam logic [10:0] COL_LIM  = 11'(COL_MAX);

    logic [10:0] r_ext;
    logic [10:0] c_ext;

    assign r_ext = {1'b0, pos_r};
    assign c_ext = {1'b0, pos_c};

    always_comb begin
        dir   = pick_dir(btn_up, btn_down, btn_left, btn_right);
        valid = 1'b0;
        case (dir)
            DIR_UP:    valid = (r_ext >= UP_MIN);
            DIR_DOWN:  valid = ((r_ext + STEP_EXT) <= ROW_LIM);
            DIR_LEFT:  valid = (c_ext >= LEFT_MIN);
            DIR_RIGHT: valid = ((c_ext + STEP_EXT) <= COL_LIM);
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/player_move_ctrl.sv
// player_move_ctrl
// Tile-based sprite movement controller. A button request in IDLE starts a
// one-tile move of STEP_PIXELS pixels, one pixel every 2^DELAY_LOG cycles.
// During a move one further request can be latched and is chained straight
// into the next move without an IDLE cycle.
// Ports:
//   clk_13                 : clock, rising edge
//   rst                    : asynchronous active-high reset
//   btn_up/down/left/right : debounced request levels
//   player_r, player_c     : sprite top-left row / column
//   move_dir               : current direction (STOP when idle)
//   frame_sel              : walk-animation frame select
//   busy                   : high while a tile move is in progress
// Build option: define WALK_ANIM_EN to drive frame_sel from the move
// counter (frame 1 during the second half of each move); otherwise 0.
module player_move_ctrl
    import game_pkg::*;
#(
    parameter int STEP_PIXELS = 32,
    parameter int DELAY_LOG   = 5,
    parameter int ROW_MIN     = 0,
    parameter int ROW_MAX     = 448,
    parameter int COL_MIN     = 0,
    parameter int COL_MAX     = 608,
    parameter int RST_ROW     = 300,
    parameter int RST_COL     = 300
) (
    input  logic       clk_13,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] player_r,
    output logic [9:0] player_c,
    output logic [2:0] move_dir,
    output logic       frame_sel,
    output logic       busy
);

    localparam int             CW       = $clog2(STEP_PIXELS) + DELAY_LOG;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(STEP_PIXELS * (2 ** DELAY_LOG) - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [9:0]    row_reg, row_next;
    logic [9:0]    col_reg, col_next;
    dir_t          dir_reg, dir_next;
    logic          pend_valid_reg, pend_valid_next;
    dir_t          pend_dir_reg, pend_dir_next;

    logic          step_tick;
    logic [9:0]    row_stepped;
    logic [9:0]    col_stepped;
    logic          is_idle;
    logic          arb_up, arb_down, arb_left, arb_right;
    dir_t          arb_dir;
    logic          arb_valid;
    dir_t          btn_dir;

    assign is_idle   = (state_reg == ST_IDLE);
    assign step_tick = (state_reg == ST_MOVE) && (cnt_reg[DELAY_LOG-1:0] == '0);
    assign btn_dir   = pick_dir(btn_up, btn_down, btn_left, btn_right);

    // Position after this edge's pixel step. The chained-move bounds check
    // at the end of a tile must see the position including the final step.
    always_comb begin
        row_stepped = row_reg;
        col_stepped = col_reg;
        if (step_tick) begin
            case (dir_reg)
                DIR_DOWN:  row_stepped = row_reg + 10'd1;
                DIR_UP:    row_stepped = row_reg - 10'd1;
                DIR_LEFT:  col_stepped = col_reg - 10'd1;
                DIR_RIGHT: col_stepped = col_reg + 10'd1;
                default:   ;
            endcase
        end
    end

    // One arbiter serves both uses: live buttons when idle, the latched
    // pending direction (as a one-hot request) while moving.
    assign arb_up    = is_idle ? btn_up    : (pend_valid_reg && pend_dir_reg == DIR_UP);
    assign arb_down  = is_idle ? btn_down  : (pend_valid_reg && pend_dir_reg == DIR_DOWN);
    assign arb_left  = is_idle ? btn_left  : (pend_valid_reg && pend_dir_reg == DIR_LEFT);
    assign arb_right = is_idle ? btn_right : (pend_valid_reg && pend_dir_reg == DIR_RIGHT);

    move_arbiter #(
        .STEP_PIXELS (STEP_PIXELS),
        .ROW_MIN     (ROW_MIN),
        .ROW_MAX     (ROW_MAX),
        .COL_MIN     (COL_MIN),
        .COL_MAX     (COL_MAX)
    ) u_arbiter (
        .btn_up    (arb_up),
        .btn_down  (arb_down),
        .btn_left  (arb_left),
        .btn_right (arb_right),
        .pos_r     (row_stepped),
        .pos_c     (col_stepped),
        .dir       (arb_dir),
        .valid     (arb_valid)
    );

    always_ff @(posedge clk_13 or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            row_reg        <= 10'(RST_ROW);
            col_reg        <= 10'(RST_COL);
            dir_reg        <= DIR_STOP;
            pend_valid_reg <= 1'b0;
            pend_dir_reg   <= DIR_STOP;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            dir_reg        <= dir_next;
            pend_valid_reg <= pend_valid_next;
            pend_dir_reg   <= pend_dir_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        dir_next        = dir_reg;
        pend_valid_next = pend_valid_reg;
        pend_dir_next   = pend_dir_reg;
        row_next        = row_stepped;
        col_next        = col_stepped;
        case (state_reg)
            ST_IDLE: begin
                pend_valid_next = 1'b0;
                if (arb_valid) begin
                    state_next = ST_MOVE;
                    cnt_next   = CNT_LOAD;
                    dir_next   = arb_dir;
                end
            end
            ST_MOVE: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == '0) begin
                    pend_valid_next = 1'b0;
                    pend_dir_next   = DIR_STOP;
                    if (arb_valid) begin
                        cnt_next = CNT_LOAD;
                        dir_next = arb_dir;
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                        dir_next   = DIR_STOP;
                    end
                end else if (!pend_valid_reg && btn_dir != DIR_STOP) begin
                    pend_valid_next = 1'b1;
                    pend_dir_next   = btn_dir;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign player_r = row_reg;
    assign player_c = col_reg;
    assign move_dir = dir_reg;
    assign busy     = (state_reg == ST_MOVE);

`ifdef WALK_ANIM_EN
    assign frame_sel = (state_reg == ST_MOVE) && !cnt_reg[CW-1];
`else
    assign frame_sel = 1'b0;
`endif

endmodule
